// File: rtl/dmem_arb_pkg.sv
// +----------------------------------------------------------------------+
// | dmem_arb_pkg : shared types and constants for dmem_arbiter           |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package dmem_arb_pkg;

   localparam int MEM_DW = 32;
   localparam int BE_W   = 4;

   typedef enum logic {
      OWN_M0 = 1'b0,
      OWN_M1 = 1'b1
   } owner_e;

   typedef struct packed {
      logic   valid;
      owner_e owner;
   } rd_tag_t;

   localparam int TAG_W = $bits(rd_tag_t);

endpackage

`default_nettype wire

// File: rtl/rd_tag_pipe.sv
// +----------------------------------------------------------------------+
// | rd_tag_pipe : RD_LAT-deep shift register of {valid, owner} read tags |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module rd_tag_pipe
   import dmem_arb_pkg::*;
#(
   parameter int RD_LAT = 1
) (
   input  logic    clk,
   input  logic    rst,
   input  rd_tag_t tag_in,
   output rd_tag_t tag_out
);

   rd_tag_t stage [RD_LAT];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < RD_LAT; i++) begin
            stage[i] <= '0;
         end
      end else begin
         stage[0] <= tag_in;
         for (int i = 1; i < RD_LAT; i++) begin
            stage[i] <= stage[i-1];
         end
      end
   end

   assign tag_out = stage[RD_LAT-1];

endmodule

`default_nettype wire

// File: rtl/dmem_arbiter.sv
// +----------------------------------------------------------------------+
// | dmem_arbiter : round-robin sharing of the data memory between the    |
// | load/store unit (m0) and the UART loader (m1).                       |
// | Optional grant counters: define DMEM_ARB_STATS_EN                    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int AW     = 12,
   parameter int RD_LAT = 1,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              m0_req,
   input  logic              m0_we,
   input  logic [AW-1:0]     m0_addr,
   input  logic [MEM_DW-1:0] m0_wdata,
   input  logic [BE_W-1:0]   m0_be,
   output logic              m0_gnt,
   output logic              m0_rvalid,
   output logic [MEM_DW-1:0] m0_rdata,
   input  logic              m1_req,
   input  logic              m1_we,
   input  logic [AW-1:0]     m1_addr,
   input  logic [MEM_DW-1:0] m1_wdata,
   input  logic [BE_W-1:0]   m1_be,
   output logic              m1_gnt,
   output logic              m1_rvalid,
   output logic [MEM_DW-1:0] m1_rdata,
`ifdef DMEM_ARB_STATS_EN
   input  logic              stats_clr,
   output logic [CNT_W-1:0]  m0_gnt_cnt,
   output logic [CNT_W-1:0]  m1_gnt_cnt,
`endif
   output logic              mem_en,
   output logic              mem_we,
   output logic [AW-1:0]     mem_addr,
   output logic [MEM_DW-1:0] mem_wdata,
   output logic [BE_W-1:0]   mem_be,
   input  logic [MEM_DW-1:0] mem_rdata
);

   owner_e  prio;
   rd_tag_t tag_in;
   rd_tag_t tag_out;

   // Requests are masked during reset so nothing reaches memory or the tag pipe.
   always_comb begin
      m0_gnt = ~rst & m0_req & (~m1_req | (prio == OWN_M0));
      m1_gnt = ~rst & m1_req & (~m0_req | (prio == OWN_M1));
   end

   always_comb begin
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      mem_be    = '0;
      if (m0_gnt) begin
         mem_en    = 1'b1;
         mem_we    = m0_we;
         mem_addr  = m0_addr;
         mem_wdata = m0_wdata;
         mem_be    = m0_be;
      end else if (m1_gnt) begin
         mem_en    = 1'b1;
         mem_we    = m1_we;
         mem_addr  = m1_addr;
         mem_wdata = m1_wdata;
         mem_be    = m1_be;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         prio <= OWN_M0;
      end else if (m0_gnt) begin
         prio <= OWN_M1;
      end else if (m1_gnt) begin
         prio <= OWN_M0;
      end
   end

   always_comb begin
      tag_in.valid = mem_en & ~mem_we;
      tag_in.owner = m1_gnt ? OWN_M1 : OWN_M0;
   end

   rd_tag_pipe #(
      .RD_LAT (RD_LAT)
   ) u_rd_tag_pipe (
      .clk     (clk),
      .rst     (rst),
      .tag_in  (tag_in),
      .tag_out (tag_out)
   );

   // The last tag stage is still loaded during the reset cycle itself, so gate it.
   assign m0_rvalid = ~rst & tag_out.valid & (tag_out.owner == OWN_M0);
   assign m1_rvalid = ~rst & tag_out.valid & (tag_out.owner == OWN_M1);
   assign m0_rdata  = mem_rdata;
   assign m1_rdata  = mem_rdata;

`ifdef DMEM_ARB_STATS_EN
   always_ff @(posedge clk) begin
      if (rst || stats_clr) begin
         m0_gnt_cnt <= '0;
         m1_gnt_cnt <= '0;
      end else begin
         if (m0_gnt && (m0_gnt_cnt != '1)) begin
            m0_gnt_cnt <= m0_gnt_cnt + 1'b1;
         end
         if (m1_gnt && (m1_gnt_cnt != '1)) begin
            m1_gnt_cnt <= m1_gnt_cnt + 1'b1;
         end
      end
   end
`endif

endmodule

`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
// +----------------------------------------------------------------------+
// | tb_dmem_arbiter : directed bench, three arbiters with RD_LAT 1/2/3   |
// | sharing one stimulus; honours DMEM_ARB_STATS_EN                      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_dmem_arbiter;

   logic        clk;
   logic        rst;
   logic        m0_req, m0_we, m1_req, m1_we;
   logic [11:0] m0_addr, m1_addr;
   logic [31:0] m0_wdata, m1_wdata;
   logic [3:0]  m0_be, m1_be;
`ifdef DMEM_ARB_STATS_EN
   logic        stats_clr;
   logic [3:0]  d_m0_cnt [3];
   logic [3:0]  d_m1_cnt [3];
`endif

   logic        d_m0_gnt [3];
   logic        d_m1_gnt [3];
   logic        d_m0_rvalid [3];
   logic        d_m1_rvalid [3];
   logic [31:0] d_m0_rdata [3];
   logic [31:0] d_m1_rdata [3];
   logic        d_mem_en [3];
   logic        d_mem_we [3];
   logic [11:0] d_mem_addr [3];
   logic [31:0] d_mem_wdata [3];
   logic [3:0]  d_mem_be [3];

   logic [31:0] mem [0:4095];
   logic [31:0] rd_q;

   int vectors = 0;
   int errors  = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   for (genvar gi = 0; gi < 3; gi++) begin : g_dut
      dmem_arbiter #(
         .AW     (12),
         .RD_LAT (gi + 1),
         .CNT_W  (4)
      ) u_dut (
         .clk        (clk),
         .rst        (rst),
         .m0_req     (m0_req),
         .m0_we      (m0_we),
         .m0_addr    (m0_addr),
         .m0_wdata   (m0_wdata),
         .m0_be      (m0_be),
         .m0_gnt     (d_m0_gnt[gi]),
         .m0_rvalid  (d_m0_rvalid[gi]),
         .m0_rdata   (d_m0_rdata[gi]),
         .m1_req     (m1_req),
         .m1_we      (m1_we),
         .m1_addr    (m1_addr),
         .m1_wdata   (m1_wdata),
         .m1_be      (m1_be),
         .m1_gnt     (d_m1_gnt[gi]),
         .m1_rvalid  (d_m1_rvalid[gi]),
         .m1_rdata   (d_m1_rdata[gi]),
`ifdef DMEM_ARB_STATS_EN
         .stats_clr  (stats_clr),
         .m0_gnt_cnt (d_m0_cnt[gi]),
         .m1_gnt_cnt (d_m1_cnt[gi]),
`endif
         .mem_en     (d_mem_en[gi]),
         .mem_we     (d_mem_we[gi]),
         .mem_addr   (d_mem_addr[gi]),
         .mem_wdata  (d_mem_wdata[gi]),
         .mem_be     (d_mem_be[gi]),
         .mem_rdata  ((gi == 0) ? rd_q : 32'h0)
      );
   end

   // One-cycle-latency byte-enabled memory behind the RD_LAT=1 instance.
   always @(posedge clk) begin
      if (d_mem_en[0]) begin
         if (d_mem_we[0]) begin
            for (int b = 0; b < 4; b++) begin
               if (d_mem_be[0][b]) mem[d_mem_addr[0]][8*b +: 8] <= d_mem_wdata[0][8*b +: 8];
            end
         end else begin
            rd_q <= mem[d_mem_addr[0]];
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_m0(input logic req, input logic we, input logic [11:0] a,
                         input logic [31:0] d, input logic [3:0] be);
      m0_req = req; m0_we = we; m0_addr = a; m0_wdata = d; m0_be = be;
   endtask

   task automatic set_m1(input logic req, input logic we, input logic [11:0] a,
                         input logic [31:0] d, input logic [3:0] be);
      m1_req = req; m1_we = we; m1_addr = a; m1_wdata = d; m1_be = be;
   endtask

   task automatic idle(input int n);
      set_m0(1'b0, 1'b0, 12'h0, 32'h0, 4'h0);
      set_m1(1'b0, 1'b0, 12'h0, 32'h0, 4'h0);
      repeat (n) tick();
   endtask

   initial begin
      logic [6:0] t4_r0;
      logic [6:0] t4_r1;
      t4_r0 = 7'b0101000;
      t4_r1 = 7'b0010000;
      mem[12'h010] = 32'hDEADBEEF;
      mem[12'h020] = 32'hAABBCCDD;
      rd_q = 32'h0;
      rst  = 1'b1;
`ifdef DMEM_ARB_STATS_EN
      stats_clr = 1'b0;
`endif
      // Requests during reset must be ignored
      set_m0(1'b1, 1'b0, 12'h010, 32'h0, 4'h0);
      set_m1(1'b1, 1'b0, 12'h020, 32'h0, 4'h0);
      tick();
      @(negedge clk);
      check("rst_m0_gnt", d_m0_gnt[0], 0);
      check("rst_m1_gnt", d_m1_gnt[0], 0);
      check("rst_mem_en", d_mem_en[0], 0);
      check("rst_mem_addr", d_mem_addr[0], 0);
      check("rst_rvalid", {d_m0_rvalid[0], d_m1_rvalid[0]}, 0);
`ifdef DMEM_ARB_STATS_EN
      check("rst_cnt0", d_m0_cnt[0], 0);
`endif
      tick();
      rst = 1'b0;

      // Single m0 read, RD_LAT=1
      idle(0);
      set_m0(1'b1, 1'b0, 12'h010, 32'h0, 4'h0);
      @(negedge clk);
      check("t1_m0_gnt", d_m0_gnt[0], 1);
      check("t1_m1_gnt", d_m1_gnt[0], 0);
      check("t1_mem_en", d_mem_en[0], 1);
      check("t1_mem_we", d_mem_we[0], 0);
      check("t1_mem_addr", d_mem_addr[0], 32'h010);
      tick();
      idle(0);
      @(negedge clk);
      check("t1_m0_rvalid", d_m0_rvalid[0], 1);
      check("t1_m0_rdata", d_m0_rdata[0], 32'hDEADBEEF);
      check("t1_m1_rvalid", d_m1_rvalid[0], 0);
      idle(4);

      // Reset pulse restores m0 priority, then both request for 6 cycles
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int k = 0; k < 7; k++) begin
         if (k < 6) begin
            set_m0(1'b1, 1'b0, 12'h010, 32'h0, 4'h0);
            set_m1(1'b1, 1'b0, 12'h020, 32'h0, 4'h0);
         end else begin
            idle(0);
         end
         @(negedge clk);
         if (k < 6) begin
            check($sformatf("t2_m0_gnt_%0d", k), d_m0_gnt[0], (k % 2 == 0) ? 1 : 0);
            check($sformatf("t2_m1_gnt_%0d", k), d_m1_gnt[0], (k % 2 == 1) ? 1 : 0);
         end
         if (k >= 1) begin
            check($sformatf("t2_m0_rv_%0d", k), d_m0_rvalid[0], ((k - 1) % 2 == 0) ? 1 : 0);
            check($sformatf("t2_m1_rv_%0d", k), d_m1_rvalid[0], ((k - 1) % 2 == 1) ? 1 : 0);
         end
         tick();
      end
      idle(4);

      // m1 partial write then m0 read-back
      set_m1(1'b1, 1'b1, 12'h020, 32'h12345678, 4'b0011);
      @(negedge clk);
      check("t3_m1_gnt", d_m1_gnt[0], 1);
      check("t3_m0_gnt", d_m0_gnt[0], 0);
      check("t3_mem_we", d_mem_we[0], 1);
      check("t3_mem_be", d_mem_be[0], 32'h3);
      check("t3_mem_wdata", d_mem_wdata[0], 32'h12345678);
      tick();
      idle(0);
      set_m0(1'b1, 1'b0, 12'h020, 32'h0, 4'h0);
      @(negedge clk);
      check("t3_rd_gnt", d_m0_gnt[0], 1);
      check("t3_wr_norv", {d_m0_rvalid[0], d_m1_rvalid[0]}, 0);
      tick();
      idle(0);
      @(negedge clk);
      check("t3_m0_rvalid", d_m0_rvalid[0], 1);
      check("t3_m1_rvalid", d_m1_rvalid[0], 0);
      check("t3_rdata", d_m0_rdata[0], 32'hAABB5678);
      idle(4);

      // RD_LAT=3: reads m0, m1, m0 on consecutive cycles
      for (int k = 0; k < 7; k++) begin
         idle(0);
         if (k == 0 || k == 2) set_m0(1'b1, 1'b0, 12'h010, 32'h0, 4'h0);
         if (k == 1) set_m1(1'b1, 1'b0, 12'h020, 32'h0, 4'h0);
         @(negedge clk);
         check($sformatf("t4_m0_rv_%0d", k), d_m0_rvalid[2], t4_r0[k]);
         check($sformatf("t4_m1_rv_%0d", k), d_m1_rvalid[2], t4_r1[k]);
         tick();
      end
      idle(4);

      // RD_LAT=2: m1 then m0 read (prio -> m1), reset flushes both
      set_m1(1'b1, 1'b0, 12'h020, 32'h0, 4'h0);
      tick();
      idle(0);
      set_m0(1'b1, 1'b0, 12'h010, 32'h0, 4'h0);
      tick();
      rst = 1'b1;
      set_m0(1'b1, 1'b0, 12'h010, 32'h0, 4'h0);
      set_m1(1'b1, 1'b0, 12'h020, 32'h0, 4'h0);
      @(negedge clk);
      check("t5_rst_gnt", {d_m0_gnt[1], d_m1_gnt[1]}, 0);
      check("t5_rst_mem_en", d_mem_en[1], 0);
      check("t5_rst_rv", {d_m0_rvalid[1], d_m1_rvalid[1]}, 0);
      tick();
      rst = 1'b0;
      @(negedge clk);
      check("t5_m0_gnt", d_m0_gnt[1], 1);
      check("t5_m1_gnt", d_m1_gnt[1], 0);
      check("t5_flush_rv", {d_m0_rvalid[1], d_m1_rvalid[1]}, 0);
      tick();
      idle(0);
      @(negedge clk);
      check("t5_flush_rv2", {d_m0_rvalid[1], d_m1_rvalid[1]}, 0);
      tick();
      @(negedge clk);
      check("t5_new_rv", d_m0_rvalid[1], 1);
      idle(4);

`ifdef DMEM_ARB_STATS_EN
      stats_clr = 1'b1;
      tick();
      stats_clr = 1'b0;
      @(negedge clk);
      check("t6_clr_cnt0", d_m0_cnt[0], 0);
      check("t6_clr_cnt1", d_m1_cnt[0], 0);
      set_m0(1'b1, 1'b0, 12'h010, 32'h0, 4'h0);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (i == 14) check("t6_cnt14", d_m0_cnt[0], 14);
         tick();
      end
      stats_clr = 1'b1;
      @(negedge clk);
      check("t6_sat", d_m0_cnt[0], 15);
      check("t6_cnt1", d_m1_cnt[0], 0);
      tick();
      stats_clr = 1'b0;
      idle(0);
      @(negedge clk);
      check("t6_clr_prec", d_m0_cnt[0], 0);
      idle(2);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule

`default_nettype wire
